// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX pipeline stage.
package id_ex_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned IMM_W  = 16;

  // ALU opcodes as carried on alu_control
  typedef enum logic [2:0] {
    ALU_ADDI   = 3'b000,
    ALU_SUBI   = 3'b001,
    ALU_TYPE_R = 3'b010,
    ALU_ANDI   = 3'b011,
    ALU_ORI    = 3'b100,
    ALU_BRFL   = 3'b101,
    ALU_CMP    = 3'b110
  } alu_op_e;

  // R-type function codes
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_MUL = 6'b011000;
  localparam logic [5:0] FUNC_DIV = 6'b011010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_NOT = 6'b100111;

  // ALU status flag codes
  typedef enum logic [1:0] {
    FLAG_NONE = 2'b00,
    FLAG_ZERO = 2'b01,
    FLAG_NEG  = 2'b10,
    FLAG_OVF  = 2'b11
  } flag_e;

  // Logical-immediate opcodes take a zero-extended immediate
  function automatic logic imm_zero_ext(input alu_op_e op);
    return (op == ALU_ANDI) || (op == ALU_ORI);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-operand forwarding selector: EX/MEM beats MEM/WB, r0 never forwarded.
module fwd_mux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exm_reg_we,
  input  logic [REG_AW-1:0] exm_rd_addr,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              mwb_reg_we,
  input  logic [REG_AW-1:0] mwb_rd_addr,
  input  logic [DATA_W-1:0] mwb_data,
  output logic [DATA_W-1:0] data_out
);

  // Pick the youngest in-flight producer of src_addr, else the register file value
  always_comb begin
    data_out = reg_data;
    if (src_addr != '0) begin
      if (exm_reg_we && (exm_rd_addr == src_addr)) begin
        data_out = exm_data;
      end else if (mwb_reg_we && (mwb_rd_addr == src_addr)) begin
        data_out = mwb_data;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall, hold and flush.
module id_ex_stage #(
  parameter int unsigned DATA_W = id_ex_stage_pkg::DATA_W,
  parameter int unsigned REG_AW = id_ex_stage_pkg::REG_AW,
  parameter int unsigned IMM_W  = id_ex_stage_pkg::IMM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [IMM_W-1:0]  id_imm,
  input  logic [2:0]        id_alu_control,
  input  logic [5:0]        id_func,
  input  logic              id_use_imm,
  input  logic              id_reg_we,
  input  logic              id_is_load,
  input  logic              exm_reg_we,
  input  logic [REG_AW-1:0] exm_rd_addr,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              mwb_reg_we,
  input  logic [REG_AW-1:0] mwb_rd_addr,
  input  logic [DATA_W-1:0] mwb_data,
  input  logic              hold,
  input  logic              flush,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [2:0]        alu_control,
  output logic [5:0]        func,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_we,
  output logic              ex_is_load
);

  import id_ex_stage_pkg::*;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [IMM_W-1:0]  imm;
    alu_op_e           op;
    logic [5:0]        func;
    logic              use_imm;
    logic              reg_we;
    logic              is_load;
  } stage_t;

  stage_t            stage_q, stage_d;
  logic              load_use;
  logic [DATA_W-1:0] fwd_a, fwd_b;
  logic [DATA_W-1:0] imm_ext;

  // Load in EX whose result the presented instruction needs next cycle
  always_comb begin
    load_use = id_valid && stage_q.valid && stage_q.is_load && (stage_q.rd_addr != '0) &&
               ((stage_q.rd_addr == id_rs_addr) ||
                ((stage_q.rd_addr == id_rt_addr) && !id_use_imm));
  end

  // Next-state priority: flush, hold, load-use bubble, capture
  always_comb begin
    stage_d  = stage_q;
    stall_id = 1'b0;
    if (flush) begin
      stage_d = '0;
    end else if (hold) begin
      stall_id = 1'b1;
    end else if (load_use) begin
      stage_d  = '0;
      stall_id = 1'b1;
    end else begin
      stage_d.valid   = id_valid;
      stage_d.rs_data = id_rs_data;
      stage_d.rt_data = id_rt_data;
      stage_d.rs_addr = id_rs_addr;
      stage_d.rt_addr = id_rt_addr;
      stage_d.rd_addr = id_rd_addr;
      stage_d.imm     = id_imm;
      stage_d.op      = alu_op_e'(id_alu_control);
      stage_d.func    = id_func;
      stage_d.use_imm = id_use_imm;
      stage_d.reg_we  = id_reg_we;
      stage_d.is_load = id_is_load;
    end
    if (reset) begin
      stall_id = 1'b0;
    end
  end

  // Stage register, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .src_addr    (stage_q.rs_addr),
    .reg_data    (stage_q.rs_data),
    .exm_reg_we  (exm_reg_we),
    .exm_rd_addr (exm_rd_addr),
    .exm_data    (exm_data),
    .mwb_reg_we  (mwb_reg_we),
    .mwb_rd_addr (mwb_rd_addr),
    .mwb_data    (mwb_data),
    .data_out    (fwd_a)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .src_addr    (stage_q.rt_addr),
    .reg_data    (stage_q.rt_data),
    .exm_reg_we  (exm_reg_we),
    .exm_rd_addr (exm_rd_addr),
    .exm_data    (exm_data),
    .mwb_reg_we  (mwb_reg_we),
    .mwb_rd_addr (mwb_rd_addr),
    .mwb_data    (mwb_data),
    .data_out    (fwd_b)
  );

  // Immediate extension chosen by the registered opcode
  always_comb begin
    if (imm_zero_ext(stage_q.op)) begin
      imm_ext = {{(DATA_W-IMM_W){1'b0}}, stage_q.imm};
    end else begin
      imm_ext = {{(DATA_W-IMM_W){stage_q.imm[IMM_W-1]}}, stage_q.imm};
    end
  end

  // Output drive; write/load flags gated so bubbles have no side effects
  always_comb begin
    ex_valid    = stage_q.valid;
    data_a      = fwd_a;
    data_b      = stage_q.use_imm ? imm_ext : fwd_b;
    alu_control = stage_q.op;
    func        = stage_q.func;
    ex_rd_addr  = stage_q.rd_addr;
    ex_reg_we   = stage_q.valid & stage_q.reg_we;
    ex_is_load  = stage_q.valid & stage_q.is_load;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expectations, negedge monitor checks.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [15:0] id_imm;
  logic [2:0]  id_alu_control;
  logic [5:0]  id_func;
  logic        id_use_imm, id_reg_we, id_is_load;
  logic        exm_reg_we;
  logic [4:0]  exm_rd_addr;
  logic [31:0] exm_data;
  logic        mwb_reg_we;
  logic [4:0]  mwb_rd_addr;
  logic [31:0] mwb_data;
  logic        hold, flush;
  logic        stall_id, ex_valid;
  logic [31:0] data_a, data_b;
  logic [2:0]  alu_control;
  logic [5:0]  func;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_we, ex_is_load;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .IMM_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_imm(id_imm), .id_alu_control(id_alu_control), .id_func(id_func),
    .id_use_imm(id_use_imm), .id_reg_we(id_reg_we), .id_is_load(id_is_load),
    .exm_reg_we(exm_reg_we), .exm_rd_addr(exm_rd_addr), .exm_data(exm_data),
    .mwb_reg_we(mwb_reg_we), .mwb_rd_addr(mwb_rd_addr), .mwb_data(mwb_data),
    .hold(hold), .flush(flush), .stall_id(stall_id), .ex_valid(ex_valid),
    .data_a(data_a), .data_b(data_b), .alu_control(alu_control), .func(func),
    .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load)
  );

  typedef struct packed {
    logic        reset, id_valid;
    logic [31:0] rs_data, rt_data;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [2:0]  op;
    logic [5:0]  func;
    logic        use_imm, we, load;
    logic        exm_we;
    logic [4:0]  exm_rd;
    logic [31:0] exm_data;
    logic        mwb_we;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_data;
    logic        hold, flush;
  } stim_t;

  // Instruction currently held in EX, as the reference sees it
  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data, rt_data;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [2:0]  op;
    logic [5:0]  func;
    logic        use_imm, we, load;
  } instr_t;

  typedef struct packed {
    logic        stall, valid;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [5:0]  func;
    logic [4:0]  rd;
    logic        we, load;
  } exp_t;

  exp_t   sb[$];
  stim_t  cur;
  instr_t m;
  int     checks = 0;
  int     passed = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic logic [31:0] fwd_ref(input logic [4:0] r, input logic [31:0] own);
    if (r == 5'd0) return own;
    if (cur.exm_we && cur.exm_rd == r) return cur.exm_data;
    if (cur.mwb_we && cur.mwb_rd == r) return cur.mwb_data;
    return own;
  endfunction

  function automatic logic [31:0] ext_ref(input logic [15:0] imm, input logic [2:0] op);
    logic [31:0] v;
    v = 32'(imm);
    if (op == 3'b011 || op == 3'b100) return v;
    if (imm >= 16'h8000) return v + 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic hazard_ref();
    if (!(cur.id_valid && m.valid && m.load && m.rd != 5'd0)) return 1'b0;
    return (m.rd == cur.rs) || (m.rd == cur.rt && !cur.use_imm);
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e.stall = !cur.reset && !cur.flush && (cur.hold || hazard_ref());
    e.valid = m.valid;
    e.a     = fwd_ref(m.rs, m.rs_data);
    e.b     = m.use_imm ? ext_ref(m.imm, m.op) : fwd_ref(m.rt, m.rt_data);
    e.op    = m.op;
    e.func  = m.func;
    e.rd    = m.rd;
    e.we    = m.valid && m.we;
    e.load  = m.valid && m.load;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    reset = s.reset; id_valid = s.id_valid;
    id_rs_data = s.rs_data; id_rt_data = s.rt_data;
    id_rs_addr = s.rs; id_rt_addr = s.rt; id_rd_addr = s.rd;
    id_imm = s.imm; id_alu_control = s.op; id_func = s.func;
    id_use_imm = s.use_imm; id_reg_we = s.we; id_is_load = s.load;
    exm_reg_we = s.exm_we; exm_rd_addr = s.exm_rd; exm_data = s.exm_data;
    mwb_reg_we = s.mwb_we; mwb_rd_addr = s.mwb_rd; mwb_data = s.mwb_data;
    hold = s.hold; flush = s.flush;
  endtask

  // One clock: advance the reference on what the edge sampled, then present new inputs
  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    if (cur.reset || cur.flush) begin
      m = '0;
    end else if (cur.hold) begin
      m = m;
    end else if (hazard_ref()) begin
      m = '0;
    end else begin
      m.valid = cur.id_valid; m.rs_data = cur.rs_data; m.rt_data = cur.rt_data;
      m.rs = cur.rs; m.rt = cur.rt; m.rd = cur.rd; m.imm = cur.imm;
      m.op = cur.op; m.func = cur.func; m.use_imm = cur.use_imm;
      m.we = cur.we; m.load = cur.load;
    end
    cur = s;
    drive(s);
    if (s.reset) m = '0;
    sb.push_back(expect_now());
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Monitor: whenever an expectation is pending, compare the DUT outputs
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("stall_id",    32'(stall_id),    32'(e.stall));
      chk("ex_valid",    32'(ex_valid),    32'(e.valid));
      chk("data_a",      data_a,           e.a);
      chk("data_b",      data_b,           e.b);
      chk("alu_control", 32'(alu_control), 32'(e.op));
      chk("func",        32'(func),        32'(e.func));
      chk("ex_rd_addr",  32'(ex_rd_addr),  32'(e.rd));
      chk("ex_reg_we",   32'(ex_reg_we),   32'(e.we));
      chk("ex_is_load",  32'(ex_is_load),  32'(e.load));
    end
  end

  initial begin
    stim_t s, add, ld;
    cur = idle();
    cur.reset = 1'b1;
    m = '0;
    drive(cur);

    s = idle(); s.reset = 1'b1;
    step(s); step(s);
    step(idle());

    // ADD r3 = r1(5) + r2(7), bypass paths aimed elsewhere
    add = idle(); add.id_valid = 1; add.rs = 1; add.rs_data = 32'h5; add.rt = 2;
    add.rt_data = 32'h7; add.rd = 3; add.op = 3'b010; add.func = 6'b100000; add.we = 1;
    s = add; s.exm_we = 1; s.exm_rd = 9; s.mwb_we = 1; s.mwb_rd = 10;
    step(s);
    s = idle(); s.hold = 1;
    step(s);
    // Both later stages write r1: EX/MEM wins
    s = idle(); s.hold = 1; s.exm_we = 1; s.exm_rd = 1; s.exm_data = 32'h10;
    s.mwb_we = 1; s.mwb_rd = 1; s.mwb_data = 32'h20;
    step(s);
    // Only MEM/WB writes r2
    s = idle(); s.hold = 1; s.mwb_we = 1; s.mwb_rd = 2; s.mwb_data = 32'h22;
    step(s);
    // rs = rt = r0 with both stages writing r0
    s = idle(); s.id_valid = 1; s.rs_data = 32'h33; s.rt_data = 32'h44; s.rd = 5;
    s.op = 3'b010; s.func = 6'b100010; s.we = 1;
    step(s);
    s = idle(); s.hold = 1; s.exm_we = 1; s.exm_data = 32'hAA; s.mwb_we = 1; s.mwb_data = 32'hBB;
    step(s);

    // Load-use: LW r4, then ADD using r4
    ld = idle(); ld.id_valid = 1; ld.rs = 7; ld.imm = 16'h8; ld.use_imm = 1; ld.rd = 4;
    ld.we = 1; ld.load = 1;
    step(ld);
    s = add; s.rs = 4;
    step(s); step(s);
    step(idle()); step(idle());

    // Immediate extension
    s = idle(); s.id_valid = 1; s.use_imm = 1; s.imm = 16'hFFFF; s.we = 1; s.rd = 6;
    step(s);
    s.op = 3'b011;
    step(s);
    s.op = 3'b100; s.imm = 16'h8001;
    step(s);
    s.op = 3'b001; s.imm = 16'h7FFF;
    step(s);
    step(idle());

    // flush together with hold drops the incoming instruction
    step(add);
    s = add; s.flush = 1; s.hold = 1;
    step(s);
    step(idle());

    // Reset asserted during a load-use stall
    step(ld);
    s = add; s.rs = 4;
    step(s);
    s.reset = 1; s.hold = 1;
    step(s);
    s.reset = 0; s.hold = 0;
    step(s);
    step(idle());

    // Randomised traffic over a small register set to provoke hazards and bypasses
    for (int i = 0; i < 400; i++) begin
      s.reset    = ($urandom_range(0, 63) == 0);
      s.id_valid = ($urandom_range(0, 3) != 0);
      s.rs_data  = $urandom; s.rt_data = $urandom;
      s.rs = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3));
      s.rd = 5'($urandom_range(0, 3));
      s.imm = 16'($urandom); s.op = 3'($urandom_range(0, 6)); s.func = 6'($urandom);
      s.use_imm = 1'($urandom); s.we = 1'($urandom); s.load = ($urandom_range(0, 2) == 0);
      s.exm_we = 1'($urandom); s.exm_rd = 5'($urandom_range(0, 3)); s.exm_data = $urandom;
      s.mwb_we = 1'($urandom); s.mwb_rd = 5'($urandom_range(0, 3)); s.mwb_data = $urandom;
      s.hold  = ($urandom_range(0, 7) == 0);
      s.flush = ($urandom_range(0, 9) == 0);
      step(s);
    end
    step(idle());

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
